// File: rtl/vote_tally.sv
// vote_tally: windowed ballot counter with per-candidate saturating tallies
// and a sequential winner scan after the voting window closes.
module vote_tally #(
  parameter int N_CAND = 3,
  parameter int CNT_W  = 8,
  localparam int WIN_W = $clog2(N_CAND)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    open_i,
  input  logic                    close_i,
  input  logic                    clear_i,
  input  logic                    vote_valid,
  input  logic [N_CAND-1:0]       vote_sel,
  output logic                    vote_ready,
  output logic [N_CAND*CNT_W-1:0] cand_cnt,
  output logic [CNT_W-1:0]        invalid_cnt,
  output logic [WIN_W-1:0]        winner,
  output logic                    tie,
  output logic                    result_valid,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] LAST_IDX = WIN_W'(N_CAND - 1);

  state_t           state_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q [N_CAND];
  logic [CNT_W-1:0] inv_q;
  logic [WIN_W-1:0] scan_q;
  logic [WIN_W-1:0] lead_q;
  logic [CNT_W-1:0] lead_cnt_q;
  logic             scan_tie_q;
  logic [WIN_W-1:0] winner_q;
  logic             tie_q;
  logic             rv_q;

  logic             accept;
  logic             onehot;
  logic             clr;
  logic [CNT_W-1:0] cur_cnt;
  logic [WIN_W-1:0] lead_d;
  logic [CNT_W-1:0] lead_cnt_d;
  logic             scan_tie_d;
  state_t           state_d;

  // Ballot acceptance, one-hot check and clear qualification
  always_comb begin
    accept = vote_valid && ready_q;
    onehot = (vote_sel != '0) &&
             ((vote_sel & (vote_sel - 1'b1)) == '0);
    clr    = clear_i && (state_q == IDLE || state_q == DONE);
  end

  // Leader comparison for the candidate currently being scanned
  always_comb begin
    cur_cnt    = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (scan_q == WIN_W'(i)) cur_cnt = cnt_q[i];
    end
    lead_d     = lead_q;
    lead_cnt_d = lead_cnt_q;
    scan_tie_d = scan_tie_q;
    if (scan_q == '0) begin
      lead_d     = '0;
      lead_cnt_d = cur_cnt;
      scan_tie_d = 1'b0;
    end else if (cur_cnt > lead_cnt_q) begin
      lead_d     = scan_q;
      lead_cnt_d = cur_cnt;
      scan_tie_d = 1'b0;
    end else if (cur_cnt == lead_cnt_q) begin
      scan_tie_d = 1'b1;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clr) state_d = IDLE;
             else if (open_i) state_d = OPEN;
      OPEN:  if (close_i) state_d = COUNT;
      COUNT: if (scan_q == LAST_IDX) state_d = DONE;
      DONE:  if (clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, registered ready, scan registers and final result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      scan_q     <= '0;
      lead_q     <= '0;
      lead_cnt_q <= '0;
      scan_tie_q <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      rv_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == OPEN);
      if (state_q == COUNT) begin
        scan_q     <= scan_q + 1'b1;
        lead_q     <= lead_d;
        lead_cnt_q <= lead_cnt_d;
        scan_tie_q <= scan_tie_d;
        if (scan_q == LAST_IDX) begin
          winner_q <= lead_d;
          tie_q    <= scan_tie_d;
          rv_q     <= 1'b1;
        end
      end else begin
        scan_q <= '0;
      end
      if (clr) begin
        winner_q <= '0;
        tie_q    <= 1'b0;
        rv_q     <= 1'b0;
      end
    end
  end

  // Saturating candidate and spoiled-ballot tallies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
      inv_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
      inv_q <= '0;
    end else if (accept) begin
      if (onehot) begin
        for (int i = 0; i < N_CAND; i++) begin
          if (vote_sel[i] && cnt_q[i] != CNT_MAX)
            cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end else if (inv_q != CNT_MAX) begin
        inv_q <= inv_q + 1'b1;
      end
    end
  end

  // Flatten tallies onto the output bus
  always_comb begin
    cand_cnt = '0;
    for (int i = 0; i < N_CAND; i++)
      cand_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  assign vote_ready   = ready_q;
  assign invalid_cnt  = inv_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign result_valid = rv_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: directed scenario checks for vote_tally
// (N_CAND=3, CNT_W=4).
module tb_vote_tally;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       open_i = 1'b0;
  logic       close_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       vote_valid = 1'b0;
  logic [2:0] vote_sel = '0;
  logic       vote_ready;
  logic [11:0] cand_cnt;
  logic [3:0] invalid_cnt;
  logic [1:0] winner;
  logic       tie;
  logic       result_valid;
  logic [1:0] state_o;

  int checks = 0;
  int failures = 0;

  logic [3:0] c0, c1, c2;
  assign c0 = cand_cnt[3:0];
  assign c1 = cand_cnt[7:4];
  assign c2 = cand_cnt[11:8];

  vote_tally #(.N_CAND(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .open_i(open_i), .close_i(close_i), .clear_i(clear_i),
    .vote_valid(vote_valid), .vote_sel(vote_sel),
    .vote_ready(vote_ready), .cand_cnt(cand_cnt),
    .invalid_cnt(invalid_cnt), .winner(winner), .tie(tie),
    .result_valid(result_valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_open();
    open_i = 1'b1;
    tick();
    open_i = 1'b0;
  endtask

  task automatic vote(input logic [2:0] s);
    vote_valid = 1'b1;
    vote_sel = s;
    tick();
    vote_valid = 1'b0;
    vote_sel = '0;
  endtask

  task automatic close_and_scan();
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({state_o, vote_ready, cand_cnt, invalid_cnt} !== 19'd0) begin
      $display("FAIL reset_state got st=%0d rdy=%0b cc=%h inv=%0d want 0",
               state_o, vote_ready, cand_cnt, invalid_cnt);
      failures++;
    end
    checks++;
    if ({winner, tie, result_valid} !== 4'd0) begin
      $display("FAIL reset_result got w=%0d t=%0b rv=%0b want 0",
               winner, tie, result_valid);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (state_o !== 2'd0) begin
      $display("FAIL reset_release got st=%0d want 0", state_o);
      failures++;
    end
  endtask

  task automatic test_basic();
    do_open();
    checks++;
    if (state_o !== 2'd1 || vote_ready !== 1'b1) begin
      $display("FAIL basic_open got st=%0d rdy=%0b want 1/1",
               state_o, vote_ready);
      failures++;
    end
    vote(3'b001); vote(3'b010); vote(3'b010);
    vote(3'b100); vote(3'b010);
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    checks++;
    if (state_o !== 2'd2 || vote_ready !== 1'b0 || result_valid !== 1'b0) begin
      $display("FAIL basic_count got st=%0d rdy=%0b rv=%0b want 2/0/0",
               state_o, vote_ready, result_valid);
      failures++;
    end
    tick();
    tick();
    checks++;
    if (result_valid !== 1'b0 || state_o !== 2'd2) begin
      $display("FAIL basic_early got rv=%0b st=%0d want 0/2",
               result_valid, state_o);
      failures++;
    end
    tick();
    checks++;
    if (state_o !== 2'd3 || result_valid !== 1'b1) begin
      $display("FAIL basic_done got st=%0d rv=%0b want 3/1",
               state_o, result_valid);
      failures++;
    end
    checks++;
    if (c0 !== 4'd1 || c1 !== 4'd3 || c2 !== 4'd1 || invalid_cnt !== 4'd0) begin
      $display("FAIL basic_tally got %0d,%0d,%0d inv=%0d want 1,3,1 inv=0",
               c2, c1, c0, invalid_cnt);
      failures++;
    end
    checks++;
    if (winner !== 2'd1 || tie !== 1'b0) begin
      $display("FAIL basic_winner got w=%0d t=%0b want 1/0", winner, tie);
      failures++;
    end
    do_clear();
    checks++;
    if ({state_o, cand_cnt, invalid_cnt, winner, tie, result_valid} !== 22'd0) begin
      $display("FAIL basic_clear got st=%0d cc=%h inv=%0d w=%0d t=%0b rv=%0b want 0",
               state_o, cand_cnt, invalid_cnt, winner, tie, result_valid);
      failures++;
    end
  endtask

  task automatic test_spoiled();
    do_open();
    vote(3'b000); vote(3'b011); vote(3'b111);
    close_and_scan();
    checks++;
    if (invalid_cnt !== 4'd3 || cand_cnt !== 12'd0) begin
      $display("FAIL spoiled_tally got inv=%0d cc=%h want 3/000",
               invalid_cnt, cand_cnt);
      failures++;
    end
    checks++;
    if (winner !== 2'd0 || tie !== 1'b1 || result_valid !== 1'b1) begin
      $display("FAIL spoiled_result got w=%0d t=%0b rv=%0b want 0/1/1",
               winner, tie, result_valid);
      failures++;
    end
    do_clear();
  endtask

  task automatic test_tie();
    do_open();
    vote(3'b001); vote(3'b100); vote(3'b100); vote(3'b001);
    close_and_scan();
    checks++;
    if (c0 !== 4'd2 || c1 !== 4'd0 || c2 !== 4'd2) begin
      $display("FAIL tie_tally got %0d,%0d,%0d want 2,0,2", c2, c1, c0);
      failures++;
    end
    checks++;
    if (winner !== 2'd0 || tie !== 1'b1) begin
      $display("FAIL tie_result got w=%0d t=%0b want 0/1", winner, tie);
      failures++;
    end
    do_clear();
  endtask

  task automatic test_saturation();
    do_open();
    for (int i = 0; i < 20; i++) vote(3'b010);
    checks++;
    if (c1 !== 4'd15 || c0 !== 4'd0 || c2 !== 4'd0) begin
      $display("FAIL sat_tally got %0d,%0d,%0d want 0,15,0", c2, c1, c0);
      failures++;
    end
    close_and_scan();
    checks++;
    if (winner !== 2'd1 || tie !== 1'b0 || invalid_cnt !== 4'd0) begin
      $display("FAIL sat_result got w=%0d t=%0b inv=%0d want 1/0/0",
               winner, tie, invalid_cnt);
      failures++;
    end
    do_clear();
  endtask

  task automatic test_close_vote();
    do_open();
    vote_valid = 1'b1;
    vote_sel = 3'b100;
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    checks++;
    if (c2 !== 4'd1 || state_o !== 2'd2 || vote_ready !== 1'b0) begin
      $display("FAIL closevote_first got c2=%0d st=%0d rdy=%0b want 1/2/0",
               c2, state_o, vote_ready);
      failures++;
    end
    tick();
    vote_valid = 1'b0;
    vote_sel = '0;
    checks++;
    if (c2 !== 4'd1 || invalid_cnt !== 4'd0) begin
      $display("FAIL closevote_ignored got c2=%0d inv=%0d want 1/0",
               c2, invalid_cnt);
      failures++;
    end
    tick();
    tick();
    checks++;
    if (state_o !== 2'd3 || winner !== 2'd2 || tie !== 1'b0) begin
      $display("FAIL closevote_result got st=%0d w=%0d t=%0b want 3/2/0",
               state_o, winner, tie);
      failures++;
    end
    do_clear();
  endtask

  task automatic test_ignored_controls();
    do_open();
    vote(3'b001); vote(3'b001);
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    open_i = 1'b1;
    tick();
    open_i = 1'b0;
    checks++;
    if (state_o !== 2'd2) begin
      $display("FAIL ign_open got st=%0d want 2", state_o);
      failures++;
    end
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    checks++;
    if (state_o !== 2'd2 || result_valid !== 1'b0) begin
      $display("FAIL ign_close got st=%0d rv=%0b want 2/0",
               state_o, result_valid);
      failures++;
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (state_o !== 2'd3 || c0 !== 4'd2 || winner !== 2'd0 || tie !== 1'b0) begin
      $display("FAIL ign_clear got st=%0d c0=%0d w=%0d t=%0b want 3/2/0/0",
               state_o, c0, winner, tie);
      failures++;
    end
    open_i = 1'b1;
    close_i = 1'b1;
    tick();
    open_i = 1'b0;
    close_i = 1'b0;
    checks++;
    if (state_o !== 2'd3 || result_valid !== 1'b1) begin
      $display("FAIL ign_done got st=%0d rv=%0b want 3/1",
               state_o, result_valid);
      failures++;
    end
    do_clear();
  endtask

  task automatic test_reset_mid_count();
    do_open();
    vote(3'b010); vote(3'b000);
    close_i = 1'b1;
    tick();
    close_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, vote_ready, cand_cnt, invalid_cnt,
         winner, tie, result_valid} !== 23'd0) begin
      $display("FAIL midreset got st=%0d rdy=%0b cc=%h inv=%0d w=%0d t=%0b rv=%0b want 0",
               state_o, vote_ready, cand_cnt, invalid_cnt,
               winner, tie, result_valid);
      failures++;
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (state_o !== 2'd0 || cand_cnt !== 12'd0) begin
      $display("FAIL midreset_release got st=%0d cc=%h want 0/000",
               state_o, cand_cnt);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spoiled();
    test_tie();
    test_saturation();
    test_close_vote();
    test_ignored_controls();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vote_tally.md
VOTE_TALLY -- requirements
Module: vote_tally

Interface
REQ-001 The block SHALL have parameter N_CAND, default 3, giving the number of candidates (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of each vote counter.
REQ-003 The block SHALL have derived localparam WIN_W = clog2(N_CAND), giving the width of the winner index.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port open_i, input, 1 bit: opens the voting window.
REQ-007 The block SHALL have port close_i, input, 1 bit: closes the voting window.
REQ-008 The block SHALL have port clear_i, input, 1 bit: zeroes all tallies and returns the block to IDLE.
REQ-009 The block SHALL have port vote_valid, input, 1 bit: a ballot is presented.
REQ-010 The block SHALL have port vote_sel, input, N_CAND bits: the ballot, one-hot candidate select.
REQ-011 The block SHALL have port vote_ready, output, 1 bit: the block accepts a ballot this cycle.
REQ-012 The block SHALL have port cand_cnt, output, N_CAND*CNT_W bits: the candidate i tally, located at bits [i*CNT_W +: CNT_W].
REQ-013 The block SHALL have port invalid_cnt, output, CNT_W bits: the count of spoiled ballots.
REQ-014 The block SHALL have port winner, output, WIN_W bits: the index of the leading candidate.
REQ-015 The block SHALL have port tie, output, 1 bit: the leading count is shared by two or more candidates.
REQ-016 The block SHALL have port result_valid, output, 1 bit: winner and tie are final.
REQ-017 The block SHALL have port state_o, output, 2 bits: the current state, encoded IDLE=0, OPEN=1, COUNT=2, DONE=3.

Function
REQ-018 The FSM SHALL make only the following transitions:
- IDLE->OPEN on open_i.
- OPEN->COUNT on close_i.
- COUNT->DONE after N_CAND cycles.
- DONE->IDLE on clear_i.
- Any state other than those listed SHALL hold.
REQ-019 vote_ready SHALL be 1 exactly when state is OPEN (a registered decode, never dependent on vote_valid).
REQ-020 A ballot SHALL be accepted on the edge where vote_valid and vote_ready are both 1, and only then.
REQ-021 If an accepted ballot has exactly one vote_sel bit set, the matching cand_cnt field SHALL increment by 1 on that edge.
REQ-022 If an accepted ballot has zero bits or two or more bits set, invalid_cnt SHALL increment by 1 and no candidate count SHALL change.
REQ-023 All counters SHALL saturate at 2^CNT_W-1; further accepted ballots leave a saturated counter unchanged, with no wrap.
REQ-024 If close_i and an accepted ballot coincide in OPEN, the ballot SHALL be counted and the state SHALL move to COUNT.
REQ-025 In IDLE, open_i SHALL take priority over close_i; close_i SHALL be ignored in IDLE, COUNT and DONE.
REQ-026 open_i SHALL be ignored in OPEN, COUNT and DONE.
REQ-027 clear_i SHALL act only in IDLE and DONE:
- It zeroes cand_cnt and invalid_cnt, winner, tie and result_valid.
- It moves the state to IDLE.
- It SHALL be ignored in OPEN and COUNT.
REQ-028 In IDLE without clear_i, the counters SHALL hold; reopening continues the tallies.
REQ-029 COUNT SHALL scan candidates sequentially, one per cycle, over scan index 0..N_CAND-1:
- Index 0 loads the leader as 0 and clears tie.
- For index i>0, a count strictly greater than the leader's replaces the leader and clears tie.
- A count equal to the leader's sets tie.
- A count less than the leader's leaves the leader and tie unchanged.
REQ-030 If close_i is sampled at edge k, the state SHALL be DONE after edge k+N_CAND, with result_valid=1 and winner and tie stable from that edge.
REQ-031 winner and tie SHALL update only at the COUNT->DONE edge; during COUNT, result_valid=0 and winner and tie hold their previous values.
REQ-032 With all tallies equal (including all zero), the result SHALL be winner=0 and tie=1.

Reset
REQ-033 rst_n low SHALL immediately, asynchronously, force the following:
- state IDLE.
- vote_ready=0.
- All cand_cnt and invalid_cnt equal to 0.
- winner=0, tie=0 and result_valid=0.
REQ-034 A reset asserted during OPEN or COUNT SHALL abort the operation; no partial result is retained.
REQ-035 Deassertion of rst_n SHALL take effect only at a rising edge, with no state change on the release edge itself.

Verification
REQ-036 Scenario, basic: with N_CAND=3, run open, then ballots 001,010,010,100,010, then close.
- Required: cand_cnt = {1,3,1} for candidates 2,1,0, and invalid_cnt=0.
- Required: winner=1 and tie=0, with result_valid high exactly 3 cycles after close.
REQ-037 Scenario, spoiled ballots: ballots 000, 011 and 111.
- Required: invalid_cnt=3 and every cand_cnt=0.
- Required: result winner=0 and tie=1.
REQ-038 Scenario, tie: ballots 001,100,100,001.
- Required: winner=0 and tie=1.
REQ-039 Scenario, saturation: with CNT_W=4, send 20 ballots of 010.
- Required: cand_cnt[1]=15, with no wrap to 4.
REQ-040 Scenario, simultaneous close and vote: vote 100 accepted on the same edge as close_i.
- Required: cand_cnt[2]=1 and state COUNT.
- Required: the next vote_valid is ignored (vote_ready=0).
REQ-041 Scenario, reset and ignored controls: assert rst_n=0 mid-COUNT.
- Required: all outputs 0 and state_o=0 without a clock edge.
- Required: open_i, close_i and clear_i pulsed in COUNT have no effect on the state sequence.
